drawing_dispatch: RTL and testbench

DRAWING_DISPATCH -- requirements
Module: drawing_dispatch

---
 rtl/drawing_pkg.sv | 18 +
 rtl/drawing_dispatch_wdog.sv | 32 +++
 rtl/drawing_dispatch.sv | 128 ++++++++++++
 tb/tb_drawing_dispatch.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/drawing_pkg.sv
// Shared constants for the drawing command dispatcher: FSM encoding and parameter legality limits.
package drawing_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_ACKUP = 3'd2;
    localparam logic [2:0] ST_RTZ   = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    localparam int NCH_MIN = 2;
    localparam int NCH_MAX = 16;

    // True when the channel count is in range and the command field can address every channel.
    function automatic logic params_ok(input int nch, input int cmd_w);
        return (nch >= NCH_MIN) && (nch <= NCH_MAX) && ((1 << cmd_w) >= nch);
    endfunction

endpackage

// File: rtl/drawing_dispatch_wdog.sv
// ISSUE-phase watchdog for drawing_dispatch; only instantiated when DRAWING_DISPATCH_TIMEOUT_EN is defined.
module drawing_dispatch_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_r;

    // Expiry fires on the TIMEOUT-th ISSUE cycle so the request is held for exactly TIMEOUT cycles.
    assign expired = run && (cnt_r == CW'(TIMEOUT - 1));

    // Cycle counter: cleared while idle, advances while the request is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (run && !expired) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/drawing_dispatch.sv
// Four-phase upstream-to-one-of-NCH channel dispatcher with registered outputs.
// Optional ISSUE watchdog enabled by defining DRAWING_DISPATCH_TIMEOUT_EN.
module drawing_dispatch
    import drawing_pkg::*;
#(
    parameter int NCH     = 8,
    parameter int CMD_W   = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             de_req,
    input  logic [CMD_W-1:0] de_cmd,
    input  logic [DW-1:0]    de_data,
    output logic             de_ack,
    output logic             de_err,
    output logic [NCH-1:0]   ch_req,
    output logic [DW-1:0]    ch_data,
    input  logic [NCH-1:0]   ch_ack,
    output logic             busy
);

    if (!params_ok(NCH, CMD_W) || (TIMEOUT < 1)) begin : g_param_check
        $error("drawing_dispatch: illegal NCH/CMD_W/TIMEOUT combination");
    end

    localparam logic [NCH-1:0] ONE = {{(NCH-1){1'b0}}, 1'b1};

    logic [2:0]       state_r;
    logic [CMD_W-1:0] cmd_q;
    logic [NCH-1:0]   sel_s;
    logic             ack_sel_s;
    logic             cmd_ok_s;
    logic             timeout_s;

    // Only the acknowledge of the latched channel is ever looked at.
    assign sel_s     = ONE << cmd_q;
    assign ack_sel_s = |(ch_ack & sel_s);
    assign cmd_ok_s  = {1'b0, de_cmd} < (CMD_W + 1)'(NCH);

`ifdef DRAWING_DISPATCH_TIMEOUT_EN
    drawing_dispatch_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_r == ST_IDLE),
        .run     (state_r == ST_ISSUE),
        .expired (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // Handshake FSM; all outputs are registered here alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cmd_q   <= {CMD_W{1'b0}};
            ch_data <= {DW{1'b0}};
            ch_req  <= {NCH{1'b0}};
            de_ack  <= 1'b0;
            de_err  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (de_req) begin
                        cmd_q   <= de_cmd;
                        ch_data <= de_data;
                        busy    <= 1'b1;
                        if (cmd_ok_s) begin
                            state_r <= ST_ISSUE;
                            ch_req  <= ONE << de_cmd;
                        end else begin
                            state_r <= ST_ERR;
                            de_ack  <= 1'b1;
                            de_err  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    // A level already high on entry counts as the acknowledge.
                    if (ack_sel_s) begin
                        state_r <= ST_ACKUP;
                        de_ack  <= 1'b1;
                        de_err  <= 1'b0;
                    end else if (timeout_s) begin
                        state_r <= ST_ERR;
                        ch_req  <= {NCH{1'b0}};
                        de_ack  <= 1'b1;
                        de_err  <= 1'b1;
                    end
                end
                ST_ACKUP: begin
                    if (!de_req) begin
                        state_r <= ST_RTZ;
                        ch_req  <= {NCH{1'b0}};
                    end
                end
                ST_RTZ: begin
                    if (!ack_sel_s) begin
                        state_r <= ST_IDLE;
                        de_ack  <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                ST_ERR: begin
                    if (!de_req) begin
                        state_r <= ST_IDLE;
                        de_ack  <= 1'b0;
                        de_err  <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ch_req  <= {NCH{1'b0}};
                    de_ack  <= 1'b0;
                    de_err  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drawing_dispatch.sv
// Self-checking bench for drawing_dispatch: an NCH=8 instance and an NCH=6/TIMEOUT=4 instance.
module tb_drawing_dispatch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req, ack, err, busy;
    logic [3:0]  cmd;
    logic [31:0] data, ch_data;
    logic [7:0]  ch_req, ch_ack;

    logic        req6, ack6, err6, busy6;
    logic [3:0]  cmd6;
    logic [31:0] data6, ch_data6;
    logic [5:0]  ch_req6, ch_ack6;

    int n_chk  = 0;
    int n_fail = 0;

    drawing_dispatch #(.NCH(8), .CMD_W(4), .DW(32), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n), .de_req(req), .de_cmd(cmd), .de_data(data),
        .de_ack(ack), .de_err(err), .ch_req(ch_req), .ch_data(ch_data),
        .ch_ack(ch_ack), .busy(busy)
    );

    drawing_dispatch #(.NCH(6), .CMD_W(4), .DW(32), .TIMEOUT(4)) dut6 (
        .clk(clk), .rst_n(rst_n), .de_req(req6), .de_cmd(cmd6), .de_data(data6),
        .de_ack(ack6), .de_err(err6), .ch_req(ch_req6), .ch_data(ch_data6),
        .ch_ack(ch_ack6), .busy(busy6)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: a command below the channel count selects that channel, anything else is an error.
    function automatic logic [7:0] exp_sel(input logic [3:0] c);
        logic [7:0] one = 8'h01;
        return (c < 4'd8) ? (one << c) : 8'h00;
    endfunction

    // One complete upstream transaction on the 8-channel instance with random timing and noise.
    task automatic run_txn(input logic [3:0] c, input logic [31:0] d);
        logic [7:0] sel;
        sel = exp_sel(c);
        cmd = c; data = d; req = 1'b1;
        step();
        chk("latch_req", ch_req, sel);
        chk("latch_data", ch_data, d);
        chk("latch_busy", busy, 1'b1);
        if (sel == 8'h00) begin
            chk("err_flags", {ack, err}, 2'b11);
            repeat ($urandom_range(0, 3)) begin
                ch_ack = 8'($urandom); cmd = 4'($urandom); data = $urandom;
                step();
                chk("err_hold", {ch_req, ack, err, busy}, {8'h00, 3'b111});
            end
            req = 1'b0;
            step();
            chk("err_done", {ch_req, ack, err, busy}, 11'h000);
        end else begin
            chk("issue_noack", ack, 1'b0);
            repeat ($urandom_range(0, 3)) begin
                ch_ack = 8'($urandom) & ~sel; cmd = 4'($urandom); data = $urandom;
                step();
                chk("issue_req", ch_req, sel);
                chk("issue_data", ch_data, d);
                chk("issue_wait", ack, 1'b0);
            end
            ch_ack = 8'($urandom) | sel;
            step();
            chk("ackup_flags", {ack, err}, 2'b10);
            chk("ackup_req", ch_req, sel);
            repeat ($urandom_range(0, 2)) begin
                step();
                chk("ackup_hold", {ch_req, ack}, {sel, 1'b1});
            end
            req = 1'b0;
            step();
            chk("rtz_req", ch_req, 8'h00);
            chk("rtz_ack", {ack, busy}, 2'b11);
            repeat ($urandom_range(0, 2)) begin
                ch_ack = 8'($urandom) | sel;
                step();
                chk("rtz_hold", ack, 1'b1);
            end
            ch_ack = 8'($urandom) & ~sel;
            step();
            chk("done", {ch_req, ack, err, busy}, 11'h000);
            chk("done_data", ch_data, d);
        end
        ch_ack = 8'h00;
    endtask

    initial begin
        rst_n = 1'b0;
        req = 1'b0; cmd = 4'd0; data = 32'd0; ch_ack = 8'h00;
        req6 = 1'b0; cmd6 = 4'd0; data6 = 32'd0; ch_ack6 = 6'h00;
        step();
        step();
        chk("reset_8", {ch_req, ch_data, ack, err, busy}, 43'd0);
        chk("reset_6", {ch_req6, ch_data6, ack6, err6, busy6}, 41'd0);
        rst_n = 1'b1;
        step();
        chk("idle_8", busy, 1'b0);

        // Basic transaction on channel 3.
        run_txn(4'd3, 32'hDEADBEEF);

        // Foreign acknowledge ignored while issuing on channel 2, then back-to-back request.
        cmd = 4'd2; data = 32'h0000_1234; req = 1'b1;
        step();
        chk("ch2_req", ch_req, 8'h04);
        ch_ack = 8'h20;
        step();
        chk("foreign_ack_req", ch_req, 8'h04);
        chk("foreign_ack_ack", ack, 1'b0);
        ch_ack = 8'h00;
        step();
        chk("foreign_ack_after", {ch_req, ack}, {8'h04, 1'b0});
        ch_ack = 8'h04;
        step();
        chk("ch2_ack", ack, 1'b1);
        req = 1'b0;
        step();
        chk("ch2_rtz", {ch_req, ack}, {8'h00, 1'b1});
        cmd = 4'd6; data = 32'hCAFE_F00D; req = 1'b1; ch_ack = 8'h00;
        step();
        chk("return_no_start", {ch_req, ack, busy}, 10'd0);
        step();
        chk("next_start", ch_req, 8'h40);
        chk("next_data", ch_data, 32'hCAFE_F00D);
        ch_ack = 8'h40;
        step();
        req = 1'b0;
        step();
        ch_ack = 8'h00;
        step();
        chk("next_done", busy, 1'b0);

        // Out-of-range commands on the 6-channel instance, including the first illegal value.
        cmd6 = 4'd7; req6 = 1'b1;
        step();
        chk("nch6_cmd7", {ch_req6, ack6, err6}, {6'h00, 2'b11});
        step();
        chk("nch6_cmd7_hold", {ch_req6, ack6, err6}, {6'h00, 2'b11});
        req6 = 1'b0;
        step();
        chk("nch6_cmd7_drop", {ack6, err6, busy6}, 3'b000);
        cmd6 = 4'd6; req6 = 1'b1;
        step();
        chk("nch6_cmd6", {ch_req6, ack6, err6}, {6'h00, 2'b11});
        req6 = 1'b0;
        step();
        cmd6 = 4'd5; req6 = 1'b1; ch_ack6 = 6'h20;
        step();
        chk("nch6_cmd5_req", ch_req6, 6'h20);
        step();
        chk("nch6_cmd5_preack", {ack6, err6}, 2'b10);
        req6 = 1'b0;
        step();
        ch_ack6 = 6'h00;
        step();
        chk("nch6_cmd5_done", {ch_req6, ack6, busy6}, 8'd0);

        // Unacknowledged issue on channel 2 of the 6-channel instance.
        cmd6 = 4'd2; req6 = 1'b1;
        step();
        chk("wdog_issue", ch_req6, 6'h04);
`ifdef DRAWING_DISPATCH_TIMEOUT_EN
        repeat (3) begin
            step();
            chk("wdog_hold", {ch_req6, ack6}, {6'h04, 1'b0});
        end
        step();
        chk("wdog_expired", {ch_req6, ack6, err6}, {6'h00, 2'b11});
        req6 = 1'b0;
        step();
        chk("wdog_clear", {ack6, err6, busy6}, 3'b000);
`else
        repeat (10) begin
            step();
            chk("no_wdog_hold", {ch_req6, ack6, err6}, {6'h04, 2'b00});
        end
        ch_ack6 = 6'h04;
        step();
        chk("no_wdog_ack", {ack6, err6}, 2'b10);
        req6 = 1'b0;
        step();
        ch_ack6 = 6'h00;
        step();
        chk("no_wdog_done", busy6, 1'b0);
`endif

        // Asynchronous reset in ACKUP with the request held high through release.
        cmd = 4'd1; data = 32'h1111_2222; req = 1'b1;
        step();
        ch_ack = 8'h02;
        step();
        step();
        chk("pre_reset_ackup", {ch_req, ack}, {8'h02, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {ch_req, ch_data, ack, err, busy}, 43'd0);
        cmd = 4'd5; data = 32'h5555_AAAA; ch_ack = 8'h00;
        #2 rst_n = 1'b1;
        step();
        chk("post_reset_req", ch_req, 8'h20);
        chk("post_reset_data", ch_data, 32'h5555_AAAA);
        ch_ack = 8'h20;
        step();
        req = 1'b0;
        step();
        ch_ack = 8'h00;
        step();
        chk("post_reset_done", busy, 1'b0);

        // Randomised transactions, legal and illegal commands mixed.
        repeat (40) begin
            run_txn(4'($urandom_range(0, 15)), $urandom);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
